data_memory_responder: RTL

- Memory-side responder for the core's data memory interface: accepts one load/store request over the valid/ready handshake, models a word-organised RAM with a programmable wait-state latency, and returns read data with a ready pulse.
- Sits behind the datapath's data port in place of the zero-latency RAM, so the pipeline stall logic can be exercised against slow memory.

---
 rtl/data_memory_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// Word-organised data RAM behind a valid/ready handshake, with LATENCY wait states per access.
// Bad addresses (misaligned, or beyond DEPTH) still complete, flagged by an error pulse alongside ready.
module data_memory_responder #(
  parameter int    ADDR_SIZE = 32,
  parameter int    DATA_SIZE = 32,
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 write_enable,
  input  logic [DATA_SIZE-1:0] write_data,
  output logic                 ready,
  output logic [DATA_SIZE-1:0] read_data,
  output logic                 error,
  output logic                 busy
);

  localparam int                   OFF_W    = $clog2(DATA_SIZE / 8);
  localparam int                   IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_SIZE-1:0] DEPTH_L  = ADDR_SIZE'(DEPTH);
  localparam logic [3:0]           LAT_L    = 4'(LATENCY);

  if (LATENCY < 0 || LATENCY > 15) begin : g_latency_range
    $error("data_memory_responder: LATENCY must lie in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_count;
  logic [3:0]           w_next_count;
  logic [ADDR_SIZE-1:0] r_addr;
  logic                 r_we;
  logic [DATA_SIZE-1:0] r_wdata;
  logic                 r_ready;
  logic                 r_error;
  logic                 r_busy;
  logic [DATA_SIZE-1:0] r_rdata;
  logic                 w_next_ready;
  logic                 w_next_error;
  logic                 w_next_busy;
  logic [DATA_SIZE-1:0] w_next_rdata;
  logic                 w_capture;
  logic                 w_mem_we;
  logic                 w_bad;
  logic [IDX_W-1:0]     w_index;
  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  function automatic logic addr_is_bad(input logic [ADDR_SIZE-1:0] a);
    logic [ADDR_SIZE-1:0] idx;
    idx = a >> OFF_W;
    return ((a & OFF_MASK) != {ADDR_SIZE{1'b0}}) || (idx >= DEPTH_L);
  endfunction

  assign w_bad   = addr_is_bad(r_addr);
  assign w_index = IDX_W'(r_addr >> OFF_W);

  // Next-state, counter and registered-output values for the IDLE/WAIT/DONE sequence.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_ready = 1'b0;
    w_next_error = 1'b0;
    w_next_busy  = r_busy;
    w_next_rdata = r_rdata;
    w_capture    = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_capture    = 1'b1;
          w_next_count = LAT_L;
          w_next_busy  = 1'b1;
          w_next_state = S_WAIT;
        end else begin
          w_next_busy  = 1'b0;
        end
      end
      S_WAIT: begin
        if (r_count != 4'd0) begin
          w_next_count = r_count - 4'd1;
        end else begin
          // Access edge: the only point where the RAM or read_data may change.
          w_next_state = S_DONE;
          w_next_ready = 1'b1;
          w_next_error = w_bad;
          w_mem_we     = r_we && !w_bad;
          if (!r_we) begin
            if (w_bad) begin
              w_next_rdata = {DATA_SIZE{1'b0}};
            end else begin
              w_next_rdata = r_mem[w_index];
            end
          end else begin
            w_next_rdata = r_rdata;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_busy  = 1'b0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_count = 4'd0;
        w_next_busy  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= {DATA_SIZE{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_ready <= w_next_ready;
      r_error <= w_next_error;
      r_busy  <= w_next_busy;
      r_rdata <= w_next_rdata;
    end
  end

  // Request capture; later input changes are ignored until the next IDLE acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= {ADDR_SIZE{1'b0}};
      r_we    <= 1'b0;
      r_wdata <= {DATA_SIZE{1'b0}};
    end else if (w_capture) begin
      r_addr  <= addr;
      r_we    <= write_enable;
      r_wdata <= write_data;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_index] <= r_wdata;
    end
  end

  assign ready     = r_ready;
  assign error     = r_error;
  assign busy      = r_busy;
  assign read_data = r_rdata;

endmodule
